// File: rtl/ppu_pkg.sv
// Shared posit8 types and constants for the PPU front end.
package ppu_pkg;

  localparam logic [7:0] POSIT8_ZERO = 8'h00;
  localparam logic [7:0] POSIT8_NAR  = 8'h80;

  typedef logic req_id_t;

  typedef struct packed {
    logic       sign;
    logic       zero;
    logic       nar;
    logic [6:0] k;
    logic [2:0] reg_len;
    logic [5:0] tail;
  } reg_dec_res_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Magnitude of a posit word with the sign bit dropped; only the 7 body bits matter.
  function automatic logic [6:0] posit8_regbits(input logic [7:0] p);
    logic [7:0] mag;
    mag = p[7] ? (~p + 8'd1) : p;
    return mag[6:0];
  endfunction

endpackage

// File: rtl/reg8.sv
// Posit8 regime decoder: measures the leading run of the 7 body bits and derives k.
module reg8 (
  input  logic [6:0]        regbits,
  output logic signed [6:0] k_val,
  output logic [2:0]        reg_length
);

  logic [6:0] run;
  logic [2:0] run_len;
  logic [6:0] run_ext;

  // run[gi] is set when every bit from the MSB down to gi matches the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_run
      assign run[gi] = (regbits[6:gi] == {(7 - gi){regbits[6]}});
    end
  endgenerate

  always_comb begin
    run_len = 3'd0;
    for (int i = 0; i < 7; i++) begin
      run_len = run_len + {2'b00, run[i]};
    end
  end

  assign run_ext    = {4'b0000, run_len};
  assign reg_length = run_len;
  assign k_val      = regbits[6] ? signed'(run_ext - 7'd1) : signed'(7'd0 - run_ext);

endmodule

// File: rtl/reg_decode_arbiter.sv
// Two-requester posit8 regime-decode front end with a registered, tagged result.
// REG_DECODE_ARB_RR_EN selects round-robin grants; otherwise port 0 has fixed priority.
module reg_decode_arbiter
  import ppu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int N    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*N-1:0]    req_posit,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_id,
  output logic                 out_sign,
  output logic                 out_zero,
  output logic                 out_nar,
  output logic signed [6:0]    out_k,
  output logic [2:0]           out_reg_len,
  output logic [5:0]           out_tail
);

  out_state_e   state_q, state_d;
  reg_dec_res_t res_q, res_d;
  req_id_t      id_q, id_d;

  logic [NREQ-1:0] grant;
  logic            free;
  logic            accept;
  req_id_t         sel;
  logic [N-1:0]    word;
  logic [6:0]      regbits;
  logic signed [6:0] k_raw;
  logic [2:0]      len_raw;
  logic [5:0]      tail_raw;
  reg_dec_res_t    dec;

  assign free = (state_q == ST_EMPTY) || out_ready;

`ifdef REG_DECODE_ARB_RR_EN
  req_id_t rr_ptr_q, rr_ptr_d;
  req_id_t rr_other;

  assign rr_other = ~rr_ptr_q;

  always_comb begin
    grant = '0;
    if (req_valid[rr_ptr_q]) begin
      grant[rr_ptr_q] = 1'b1;
    end else if (req_valid[rr_other]) begin
      grant[rr_other] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = ~sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign grant = {req_valid[1] & ~req_valid[0], req_valid[0]};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = grant[gi] & free;
    end
  endgenerate

  assign accept  = |(req_valid & req_ready);
  assign sel     = grant[1];
  assign word    = sel ? req_posit[2*N-1:N] : req_posit[N-1:0];
  assign regbits = posit8_regbits(word);

  reg8 u_reg8 (
    .regbits    (regbits),
    .k_val      (k_raw),
    .reg_length (len_raw)
  );

  // Shifting by c and keeping 6 bits equals the top 6 of a 7-bit shift by c+1.
  assign tail_raw = 6'(regbits << len_raw);

  always_comb begin
    dec      = '0;
    dec.sign = word[7];
    if (word == POSIT8_ZERO) begin
      dec.zero = 1'b1;
    end else if (word == POSIT8_NAR) begin
      dec.nar = 1'b1;
    end else begin
      dec.k       = k_raw;
      dec.reg_len = len_raw;
      dec.tail    = tail_raw;
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    id_d    = id_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept) begin
      res_d = dec;
      id_d  = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      res_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      id_q    <= id_d;
    end
  end

  assign out_valid   = (state_q == ST_FULL);
  assign out_id      = id_q;
  assign out_sign    = res_q.sign;
  assign out_zero    = res_q.zero;
  assign out_nar     = res_q.nar;
  assign out_k       = res_q.k;
  assign out_reg_len = res_q.reg_len;
  assign out_tail    = res_q.tail;

endmodule
